// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequences the single-port data memory and shares it between
// the pipeline MEM stage and a debug/loader port.
//
// Handshakes:
//   cpu_req_i is held stable while cpu_stall_o=1. The access completes in the
//   cycle cpu_stall_o drops, and cpu_rdata_o is valid then.
//   dbg_req_i is held until dbg_valid_o, which is a one-cycle completion pulse.
//   mem_en_o is a one-cycle strobe. mem_addr_o and mem_wdata_o are held until
//   mem_ack_i, which may arrive one or more cycles after the strobe. mem_ack_i
//   is only honoured while waiting for an acknowledge.
module dmem_arbiter #(
  parameter int DMEM_BYTES = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [31:0]      cpu_addr_i,
  input  logic [31:0]      cpu_wdata_i,
  output logic [31:0]      cpu_rdata_o,
  output logic             cpu_stall_o,
  input  logic             dbg_req_i,
  input  logic             dbg_we_i,
  input  logic [31:0]      dbg_addr_i,
  input  logic [31:0]      dbg_wdata_i,
  output logic [31:0]      dbg_rdata_o,
  output logic             dbg_valid_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_ack_i,
  output logic             err_o,
  output logic [31:0]      err_addr_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [1:0]       fsm_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [31:0]      LAST_WORD  = 32'(DMEM_BYTES - 4);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_next;
  logic              r_owner_dbg;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [SW-1:0]     r_starve;
  logic [31:0]       r_cpu_rdata;
  logic [31:0]       r_dbg_rdata;
  logic              r_err;
  logic [31:0]       r_err_addr;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_any;
  logic              w_cpu_sel;
  logic              w_sel_we;
  logic [31:0]       w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic              w_fault;
  logic              w_stall;

  // Arbitration: CPU has priority unless debug has been passed over STARVE_MAX times.
  assign w_any       = cpu_req_i | dbg_req_i;
  assign w_cpu_sel   = cpu_req_i & (~dbg_req_i | (r_starve != STARVE_LIM));
  assign w_sel_we    = w_cpu_sel ? cpu_we_i    : dbg_we_i;
  assign w_sel_addr  = w_cpu_sel ? cpu_addr_i  : dbg_addr_i;
  assign w_sel_wdata = w_cpu_sel ? cpu_wdata_i : dbg_wdata_i;
  assign w_fault     = (w_sel_addr[1:0] != 2'b00) | (w_sel_addr > LAST_WORD);

  // Stall is combinational from the request so the pipeline freezes in the same cycle.
  assign w_stall = cpu_req_i & ~((r_state == S_DONE) & ~r_owner_dbg);

  assign cpu_stall_o    = w_stall;
  assign cpu_rdata_o    = r_cpu_rdata;
  assign dbg_rdata_o    = r_dbg_rdata;
  assign dbg_valid_o    = (r_state == S_DONE) & r_owner_dbg;
  assign mem_en_o       = (r_state == S_ISSUE);
  assign mem_we_o       = r_we & ((r_state == S_ISSUE) | (r_state == S_WAIT));
  assign mem_addr_o     = r_addr;
  assign mem_wdata_o    = r_wdata;
  assign err_o          = r_err;
  assign err_addr_o     = r_err_addr;
  assign stall_cycles_o = r_stall_cnt;
  assign fsm_state_o    = r_state;

  // Next-state logic; a faulting access skips the memory and completes directly.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = w_fault ? S_DONE : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (mem_ack_i) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register, transaction latches, starvation counter and error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner_dbg <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_starve    <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_err       <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_any) begin
        r_owner_dbg <= ~w_cpu_sel;
        if (!w_cpu_sel) begin
          r_starve <= '0;
        end else if (dbg_req_i && (r_starve != STARVE_LIM)) begin
          r_starve <= r_starve + 1'b1;
        end
        if (w_fault) begin
          // Faulting reads return zero; faulting stores are dropped.
          r_err <= 1'b1;
          if (!r_err) r_err_addr <= w_sel_addr;
          if (!w_sel_we) begin
            if (w_cpu_sel) r_cpu_rdata <= '0;
            else           r_dbg_rdata <= '0;
          end
        end else begin
          r_we    <= w_sel_we;
          r_addr  <= w_sel_addr;
          r_wdata <= w_sel_wdata;
        end
      end
      if ((r_state == S_WAIT) && mem_ack_i && !r_we) begin
        if (r_owner_dbg) r_dbg_rdata <= mem_rdata_i;
        else             r_cpu_rdata <= mem_rdata_i;
      end
    end
  end

  // Saturating count of cycles in which the pipeline is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_SAT)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
